// File: rtl/spi_reg_ctrl_if.sv
// Command/response bus between a register client and spi_reg_ctrl.
// The client side uses the master modport, the controller the slave modport.
interface spi_reg_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rw;
  logic [6:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       busy;

  modport master (
    output cmd_valid, cmd_rw, cmd_addr, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  cmd_valid, cmd_rw, cmd_addr, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/spi_reg_ctrl.sv
// Register-access controller in front of a CS-framed SPI master.
// One command at a time: header byte {rw,addr}, then a data byte (write data
// or 8'h00 for reads), then wait for both received bytes and respond.
// A cycle budget from accept to response turns a stuck master into rsp_err.
module spi_reg_ctrl #(
  parameter int TIMEOUT_CLKS = 1024
) (
  input  logic             clk,
  input  logic             reset,
  spi_reg_ctrl_if.slave    bus,
  output logic [1:0]       m_mosi_count,
  output logic [7:0]       m_mosi_byte,
  output logic             m_mosi_tick,
  input  logic             m_mosi_ready,
  input  logic             m_miso_tick,
  input  logic [7:0]       m_miso_byte,
  input  logic [1:0]       m_miso_count
);

  localparam int              TW       = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0]   TMO_MAX  = TW'(TIMEOUT_CLKS);
  localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CLKS - 1);

  typedef enum logic [2:0] {
    IDLE, HDR_WAIT, HDR_TICK, DAT_WAIT, DAT_TICK, RX_WAIT, RESP
  } state_t;

  typedef struct packed {
    logic       rw;
    logic [7:0] hdr;
    logic [7:0] dat;
  } cmd_t;

  state_t          state, state_nx;
  cmd_t            cmd_q;
  logic            guard;      // first cycle of the current state
  logic [1:0]      rx_cnt;
  logic [TW-1:0]   tmo_cnt;
  logic [7:0]      rd_buf;     // read byte captured from the master
  logic [7:0]      rdata_q;
  logic            err_q;
  logic [7:0]      mosi_byte_q;

  logic            accept, active, rx_win, tmo_hit;
  logic            cmd_ready_c, busy_c, rsp_valid_c, mosi_tick_c;

  assign accept  = (state == IDLE) && bus.cmd_valid;
  assign active  = (state != IDLE) && (state != RESP);
  assign rx_win  = (state == DAT_WAIT) || (state == DAT_TICK) || (state == RX_WAIT);
  // tmo_cnt+1 active cycles have elapsed by the end of this one
  assign tmo_hit = active && (tmo_cnt >= TMO_LAST);

  // state register
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // next-state decode; timeout overrides every other transition
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (bus.cmd_valid) state_nx = HDR_WAIT;
      HDR_WAIT: if (!guard && m_mosi_ready) state_nx = HDR_TICK;
      HDR_TICK: state_nx = DAT_WAIT;
      DAT_WAIT: if (!guard && m_mosi_ready) state_nx = DAT_TICK;
      DAT_TICK: state_nx = RX_WAIT;
      RX_WAIT:  if (rx_cnt == 2'd2) state_nx = RESP;
      RESP:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
    if (tmo_hit) state_nx = RESP;
  end

  // outputs decoded from the state register only
  always_comb begin
    cmd_ready_c = 1'b0;
    busy_c      = 1'b1;
    rsp_valid_c = 1'b0;
    mosi_tick_c = 1'b0;
    case (state)
      IDLE:     begin cmd_ready_c = 1'b1; busy_c = 1'b0; end
      HDR_TICK: mosi_tick_c = 1'b1;
      DAT_TICK: mosi_tick_c = 1'b1;
      RESP:     rsp_valid_c = 1'b1;
      default:  ;
    endcase
  end

  // command latch, counters, byte capture and response registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      cmd_q       <= '0;
      guard       <= 1'b0;
      rx_cnt      <= 2'd0;
      tmo_cnt     <= '0;
      rd_buf      <= 8'h00;
      rdata_q     <= 8'h00;
      err_q       <= 1'b0;
      mosi_byte_q <= 8'h00;
    end else begin
      guard <= (state_nx != state);
      if (accept) begin
        cmd_q.rw  <= bus.cmd_rw;
        cmd_q.hdr <= {bus.cmd_rw, bus.cmd_addr};
        cmd_q.dat <= bus.cmd_rw ? 8'h00 : bus.cmd_wdata;
        rx_cnt    <= 2'd0;
        tmo_cnt   <= '0;
        rd_buf    <= 8'h00;
      end else begin
        if (active && (tmo_cnt != TMO_MAX)) tmo_cnt <= tmo_cnt + TW'(1);
        if (rx_win && m_miso_tick) begin
          if (rx_cnt != 2'd2) rx_cnt <= rx_cnt + 2'd1;
          if ((m_miso_count == 2'd1) && cmd_q.rw) rd_buf <= m_miso_byte;
        end
      end
      // byte is loaded on entry to a tick state and held afterwards
      if (state_nx == HDR_TICK) mosi_byte_q <= cmd_q.hdr;
      if (state_nx == DAT_TICK) mosi_byte_q <= cmd_q.dat;
      // response fields change only when a response is issued
      if ((state_nx == RESP) && (state != RESP)) begin
        err_q   <= tmo_hit;
        rdata_q <= (!tmo_hit && cmd_q.rw) ? rd_buf : 8'h00;
      end
    end
  end

  assign bus.cmd_ready = cmd_ready_c;
  assign bus.busy      = busy_c;
  assign bus.rsp_valid = rsp_valid_c;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign m_mosi_tick   = mosi_tick_c;
  assign m_mosi_byte   = mosi_byte_q;
  assign m_mosi_count  = 2'd2;

endmodule

// File: doc/spi_reg_ctrl.md
SPI_REG_CTRL -- requirements
Module: spi_reg_ctrl

Interface
REQ-001 The module SHALL have parameter TIMEOUT_CLKS, default 1024: the maximum number of clocks from command acceptance to response before an error is declared.
REQ-002 clk  in  1  single clock; all logic SHALL use its rising edge.
REQ-003 reset  in  1  reset, synchronous and active-low.
REQ-004 cmd_valid  in  1  command request.
REQ-005 cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high on a clk edge.
REQ-006 cmd_rw  in  1  1=read, 0=write.
REQ-007 cmd_addr  in  7  register address.
REQ-008 cmd_wdata  in  8  write data, ignored for reads.
REQ-009 rsp_valid  out  1  response strobe, one clk wide.
REQ-010 rsp_rdata  out  8  read data, valid with rsp_valid.
REQ-011 rsp_err  out  1  timeout flag, valid with rsp_valid.
REQ-012 busy  out  1  high whenever the state is not IDLE.
REQ-013 m_mosi_count  out  2  bytes per CS frame, driven to constant 2.
REQ-014 m_mosi_byte  out  8  byte presented to the CS-framed SPI master.
REQ-015 m_mosi_tick  out  1  byte-valid pulse to the master.
REQ-016 m_mosi_ready  in  1  master ready; the master gates this with m_mosi_tick combinationally.
REQ-017 m_miso_tick  in  1  master received-byte pulse.
REQ-018 m_miso_byte  in  8  master received byte.
REQ-019 m_miso_count  in  2  master received-byte index, 0 for the first byte of a frame.

Function
REQ-020 The FSM SHALL have these states: IDLE, HDR_WAIT, HDR_TICK, DAT_WAIT, DAT_TICK, RX_WAIT, RESP.
REQ-021 cmd_ready SHALL be high only in IDLE and SHALL be decoded from state registers only, with no combinational path from any input.
REQ-022 IDLE: on accept, the block SHALL latch hdr={cmd_rw,cmd_addr}, dat=(cmd_rw ? 8'h00 : cmd_wdata) and rw, clear rx_cnt and tmo_cnt, and go to HDR_WAIT.
REQ-023 HDR_WAIT / DAT_WAIT: m_mosi_ready SHALL be ignored in the first cycle of the state (guard cycle); in any later cycle with m_mosi_ready=1 the FSM SHALL go to HDR_TICK / DAT_TICK respectively.
REQ-024 HDR_TICK / DAT_TICK SHALL last exactly one cycle, with m_mosi_tick=1 and m_mosi_byte=hdr / dat; the next state SHALL be DAT_WAIT / RX_WAIT unconditionally.
REQ-025 m_mosi_tick SHALL be registered (a flop or pure state decode) and SHALL never be derived combinationally from m_mosi_ready.
REQ-026 m_mosi_byte SHALL hold its last value outside the TICK states.
REQ-027 From DAT_WAIT onward, each m_miso_tick SHALL increment rx_cnt, saturating at 2.
REQ-028 On an m_miso_tick with m_miso_count==1 and rw=1, m_miso_byte SHALL be captured into rsp_rdata.
REQ-029 RX_WAIT SHALL go to RESP in the cycle after rx_cnt reaches 2, with rsp_err=0.
REQ-030 tmo_cnt SHALL count every cycle outside IDLE and RESP and saturate.
REQ-031 When tmo_cnt reaches TIMEOUT_CLKS in any non-IDLE, non-RESP state, the FSM SHALL go to RESP with rsp_err=1 and rsp_rdata=8'h00; the timeout SHALL take priority over every other transition in that cycle.
REQ-032 RESP SHALL last one cycle with rsp_valid=1 and then go to IDLE, so the earliest next accept is the cycle after RESP.
REQ-033 rsp_rdata SHALL be 8'h00 for writes and SHALL hold its value until the next RESP.
REQ-034 Best-case accept-to-rsp_valid latency SHALL be 5 cycles plus master transfer time; at most one command SHALL be outstanding.
REQ-035 m_miso_tick pulses arriving in IDLE or RESP SHALL be ignored.
REQ-036 After a timeout, no abort SHALL be issued to the master; master recovery is a system-level responsibility.

Reset
REQ-037 When reset=0 at a clk edge, the block SHALL enter IDLE and clear rx_cnt and tmo_cnt.
REQ-038 Outputs SHALL reset as follows: rsp_valid=0, rsp_err=0, rsp_rdata=8'h00, m_mosi_tick=0, m_mosi_byte=8'h00, busy=0, cmd_ready=1 from the first cycle after reset is released.
REQ-039 Reset asserted mid-transaction SHALL abandon the command with no rsp_valid issued.

Verification
REQ-040 Write cmd_rw=0, addr=7'h15, wdata=8'hA5, with a behavioural CS master -> mosi bytes 8'h15 then 8'hA5, each tick exactly one cycle wide; rsp_valid with rsp_err=0 and rsp_rdata=8'h00.
REQ-041 Read addr=7'h7F, master returns 8'h3C then 8'hC3 -> header byte 8'hFF, data byte 8'h00, rsp_rdata=8'hC3, rsp_err=0.
REQ-042 m_mosi_ready held high continuously -> each tick still preceded by a guard cycle, no back-to-back ticks, exactly 2 ticks per command.
REQ-043 TIMEOUT_CLKS=16 and master never raises m_mosi_ready -> rsp_valid with rsp_err=1 exactly 16 cycles after HDR_WAIT entry; cmd_ready returns the next cycle.
REQ-044 reset pulled low during RX_WAIT -> no rsp_valid; all outputs at reset values; a new command is accepted the cycle after reset is released.
REQ-045 Two commands presented back-to-back with cmd_valid held high -> second accepted exactly one cycle after the first rsp_valid; responses in order.
